// File: rtl/fsk_mary_encoder.sv
// M-ary FSK encoder: K-bit symbols in over valid/ready, phase-continuous
// square-wave carrier out with a per-symbol half-period, SYM_LEN clocks per symbol.
module fsk_mary_encoder #(
  parameter int BITS_PER_SYM = 1,
  parameter int SYM_LEN      = 16,
  parameter int HALF_MAX     = 8,
  parameter int HALF_STEP    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sending,
  input  logic [BITS_PER_SYM-1:0] codein,
  input  logic                    code_valid,
  output logic                    code_ready,
  output logic                    FSKout,
  output logic                    busy,
  output logic                    underrun
);

  localparam int M  = 2 ** BITS_PER_SYM;
  localparam int SW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int HW = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam logic [SW-1:0] SYM_LAST = SW'(SYM_LEN - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  if (HALF_MAX - (M - 1) * HALF_STEP < 1) begin : g_bad_half
    $error("fsk_mary_encoder: highest tone half-period is below 1");
  end
  if (SYM_LEN < 2) begin : g_bad_len
    $error("fsk_mary_encoder: SYM_LEN must be at least 2");
  end

  // Terminal half-period count for each tone, H(i)-1.
  logic [HW-1:0] half_last [M];
  for (genvar gi = 0; gi < M; gi++) begin : g_half
    assign half_last[gi] = HW'(HALF_MAX - 1 - gi * HALF_STEP);
  end

  logic [0:0]              state_q, state_d;
  logic [BITS_PER_SYM-1:0] cur_sym_q, cur_sym_d;
  logic [SW-1:0]           sym_cnt_q, sym_cnt_d;
  logic [HW-1:0]           half_cnt_q, half_cnt_d;
  logic                    fsk_q, fsk_d;
  logic                    underrun_q, underrun_d;

  logic accept;
  logic boundary;
  logic toggle;
  logic fsk_next;

  assign boundary   = (sym_cnt_q == SYM_LAST);
  assign code_ready = sending & ~reset & ((state_q == IDLE) | boundary);
  assign accept     = code_valid & code_ready;
  assign toggle     = (half_cnt_q == half_last[cur_sym_q]);
  assign fsk_next   = toggle ? ~fsk_q : fsk_q;

  always_comb begin
    state_d    = state_q;
    cur_sym_d  = cur_sym_q;
    sym_cnt_d  = sym_cnt_q;
    half_cnt_d = half_cnt_q;
    fsk_d      = fsk_q;
    underrun_d = 1'b0;
    if (!sending) begin
      state_d    = IDLE;
      cur_sym_d  = '0;
      sym_cnt_d  = '0;
      half_cnt_d = '0;
      fsk_d      = 1'b0;
    end else if (state_q == IDLE) begin
      fsk_d = 1'b0;
      if (accept) begin
        state_d    = RUN;
        cur_sym_d  = codein;
        sym_cnt_d  = '0;
        half_cnt_d = '0;
        fsk_d      = 1'b1;
      end
    end else if (boundary) begin
      sym_cnt_d  = '0;
      half_cnt_d = '0;
      // Next symbol inherits the toggled level so the carrier stays continuous.
      if (accept) begin
        cur_sym_d = codein;
        fsk_d     = fsk_next;
      end else begin
        state_d    = IDLE;
        cur_sym_d  = '0;
        fsk_d      = 1'b0;
        underrun_d = 1'b1;
      end
    end else begin
      sym_cnt_d  = sym_cnt_q + SW'(1);
      half_cnt_d = toggle ? '0 : half_cnt_q + HW'(1);
      fsk_d      = fsk_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_sym_q  <= '0;
      sym_cnt_q  <= '0;
      half_cnt_q <= '0;
      fsk_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_sym_q  <= cur_sym_d;
      sym_cnt_q  <= sym_cnt_d;
      half_cnt_q <= half_cnt_d;
      fsk_q      <= fsk_d;
      underrun_q <= underrun_d;
    end
  end

  assign FSKout   = fsk_q;
  assign busy     = (state_q == RUN);
  assign underrun = underrun_q;

endmodule
